pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard, flush and memory-freeze controller for the five-stage pipeline (IF, ID, EXE, MEM, WB) fed by the opcode decoder. It keeps a shadow scoreboard of the instructions in EXE, MEM and WB. From that scoreboard it stalls ID on read-after-write hazards, flushes on taken branches, and freezes the whole pipeline while a load or store completes a request/ready handshake with the data SRAM. It is the only source of stall, flush and freeze control in the core.

## Interface
- FORWARD_EN, default 1: 1 means the forwarding unit is present, so only load-use hazards stall. 0 means no forwarding, so any in-flight producer stalls.
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ID_Valid  input  1  the ID stage holds a real instruction.
- ID_Src1  input  5  first source register of the ID instruction.
- ID_Src2  input  5  second source register of the ID instruction.
- ID_Two_Src  input  1  ID_Src2 is actually read (R-type, ST, BNE).
- ID_Dest  input  5  destination register of the ID instruction.
- ID_WB_En  input  1  decoded write-back enable of the ID instruction.
- ID_MEM_R_En  input  1  decoded memory-read enable of the ID instruction.
- ID_MEM_W_En  input  1  decoded memory-write enable of the ID instruction.
- Branch_Taken  input  1  EXE resolved a taken BEZ, BNE or JMP this cycle.
- SRAM_Ready  input  1  the SRAM has completed the current request.
- Hazard_Stall  output  1  hold the PC and the IF/ID register; insert a bubble into EXE.
- Flush  output  1  clear the IF/ID register; insert a bubble into EXE; the PC loads the branch target.
- Freeze  output  1  hold every pipeline register, including the PC.
- SRAM_Req  output  1  memory access request for the instruction in MEM.

## Operation
- **Scoreboard.** There are three slots: EXE, MEM and WB. Each slot holds {valid, dest[4:0], wb, memr, memw}.
- **Slot advance.** When Freeze=0, on every edge:
  - WB<=MEM.
  - MEM<=EXE.
  - EXE<=ID fields if Issue, otherwise an invalid bubble.
  - Issue = ID_Valid & ~Hazard_Stall & ~Flush.
  - When Freeze=1, all slots hold.
- **Match.** match(slot, s) = slot.valid & slot.wb & (slot.dest == s) & (s != 0). Register 0 never creates a hazard.
- **Sources checked.** ID_Src1 is always checked. ID_Src2 is checked only when ID_Two_Src=1.
- **Hazard with FORWARD_EN=1.** The raw hazard is match(EXE, src) with EXE.memr=1 (load-use only).
- **Hazard with FORWARD_EN=0.** The raw hazard is match(EXE, src) or match(MEM, src).
  - The WB slot is never a hazard, because the register file writes on the falling edge.
- **Priority.** Freeze > Flush > Hazard_Stall.
  - Flush = Branch_Taken & ~Freeze.
  - Hazard_Stall = raw hazard & ID_Valid & ~Flush & ~Freeze.
  - Flush and Hazard_Stall are never high together.
- **Memory FSM.** The FSM has three states: M_IDLE, M_BUSY and M_DONE. Let mem_op = MEM.valid & (MEM.memr | MEM.memw).
  - M_IDLE: if mem_op, go to M_BUSY. Otherwise stay.
  - M_BUSY: if SRAM_Ready, go to M_DONE. Otherwise stay.
  - M_DONE: always go to M_IDLE. The pipeline advances in this cycle, so the completed operation leaves MEM.
  - Freeze = SRAM_Req = (M_IDLE & mem_op) | M_BUSY.
- **SRAM_Ready outside M_BUSY.** It is ignored in M_IDLE and M_DONE.

## Timing
- **Reset.** Asserting rst_n low immediately forces:
  - all slots invalid;
  - FSM in M_IDLE;
  - Hazard_Stall=0, Flush=0, Freeze=0, SRAM_Req=0.
  - This holds even in mid-access, so SRAM_Req drops without waiting for an edge.
- **Combinational outputs.** Hazard_Stall and Flush are combinational from the ID inputs, Branch_Taken and registered state. They have zero latency.
- **Freeze and SRAM_Req.** Both rise in the same cycle a memory op enters MEM. Both stay high through the cycle in which SRAM_Ready is sampled high. Both are low in the following M_DONE cycle.
  - Minimum freeze is 2 cycles, when SRAM_Ready is high in the first M_BUSY cycle.
- **Back-to-back memory ops.** The second op enters MEM at the M_DONE edge. That restarts the handshake from M_IDLE, with no idle gap.
- **Branch during freeze.** Branch_Taken is not acted on while Freeze=1. EXE holds the branch, so the decision is re-presented when the freeze ends.
- **Stall length, FORWARD_EN=0.**
  - Dependent instruction directly behind its producer: 2 stall cycles.
  - One independent instruction between them: 1 stall cycle.
- **Stall length, FORWARD_EN=1.** Load-use: exactly 1 stall cycle.

## Test plan
- **No forwarding.** FORWARD_EN=0; ADD R1 issued, then ADD R2,R1,R4 in ID → Hazard_Stall=1 for 2 cycles, then Issue; EXE receives 2 bubbles.
- **Forwarding.** FORWARD_EN=1; same sequence → Hazard_Stall never high. Then LD R3 followed by SUB R5,R3,R3 → exactly 1 stall cycle.
- **R0 and unused source.**
  - Producer writes R0; consumer reads R0 → no stall.
  - ID_Two_Src=0 with ID_Src2 matching → no stall.
- **Memory handshake.** ST enters MEM at cycle 0; SRAM_Ready low in cycles 1-2, high in cycle 3 → Freeze=SRAM_Req=1 in cycles 0-3, 0 in cycle 4; slots unchanged in cycles 0-3.
- **Branch versus hazard.** Branch_Taken=1 while a load-use hazard is present → Flush=1, Hazard_Stall=0; EXE receives a bubble next edge.
- **Branch and reset during memory access.**
  - Branch_Taken=1 while Freeze=1 → Flush=0.
  - rst_n driven low in M_BUSY → SRAM_Req and Freeze 0 immediately; after release, FSM is in M_IDLE with empty slots.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline-to-hazard-controller signal bundle
//
// Purpose: carries the ID-stage decode fields, branch resolution and SRAM
// handshake into the hazard controller, and returns the stall/flush/freeze
// controls.
//
// Signals:
//   ID_Valid, ID_Src1, ID_Src2, ID_Two_Src, ID_Dest,
//   ID_WB_En, ID_MEM_R_En, ID_MEM_W_En   ID-stage instruction description
//   Branch_Taken                         EXE resolved a taken branch/jump
//   SRAM_Ready                           SRAM finished the current request
//   Hazard_Stall, Flush, Freeze          pipeline control back to the core
//   SRAM_Req                             memory request for the MEM instruction
//   Scoreboard                           {EXE, MEM, WB} slots, 9 bits each:
//                                        {valid, dest[4:0], wb, memr, memw}
//
// Modports: master = pipeline side, slave = hazard controller.
interface pipeline_hazard_ctrl_if;
    logic        ID_Valid;
    logic [4:0]  ID_Src1;
    logic [4:0]  ID_Src2;
    logic        ID_Two_Src;
    logic [4:0]  ID_Dest;
    logic        ID_WB_En;
    logic        ID_MEM_R_En;
    logic        ID_MEM_W_En;
    logic        Branch_Taken;
    logic        SRAM_Ready;
    logic        Hazard_Stall;
    logic        Flush;
    logic        Freeze;
    logic        SRAM_Req;
    logic [26:0] Scoreboard;

    modport master (
        output ID_Valid, ID_Src1, ID_Src2, ID_Two_Src, ID_Dest,
               ID_WB_En, ID_MEM_R_En, ID_MEM_W_En, Branch_Taken, SRAM_Ready,
        input  Hazard_Stall, Flush, Freeze, SRAM_Req, Scoreboard
    );

    modport slave (
        input  ID_Valid, ID_Src1, ID_Src2, ID_Two_Src, ID_Dest,
               ID_WB_En, ID_MEM_R_En, ID_MEM_W_En, Branch_Taken, SRAM_Ready,
        output Hazard_Stall, Flush, Freeze, SRAM_Req, Scoreboard
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - RAW stall, branch flush and SRAM freeze controller
//
// Purpose: shadows the EXE/MEM/WB instructions in a three-slot scoreboard,
// stalls ID on read-after-write hazards, flushes on taken branches and
// freezes the whole pipeline while MEM completes an SRAM handshake.
//
// Ports:
//   clk    pipeline clock, rising edge
//   rst_n  asynchronous active-low reset
//   hz     pipeline_hazard_ctrl_if.slave (decode fields in, controls out)
//
// Parameter:
//   FORWARD_EN  1: forwarding present, only load-use stalls
//               0: any EXE/MEM producer of a read source stalls
module pipeline_hazard_ctrl #(
    parameter bit FORWARD_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       wb;
        logic       memr;
        logic       memw;
    } slot_t;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_BUSY = 2'd1,
        M_DONE = 2'd2
    } mem_state_t;

    slot_t      exe_q, mem_q, wb_q;
    slot_t      exe_d, mem_d, wb_d;
    slot_t      id_slot;
    mem_state_t mstate_q;

    logic mem_op;
    logic freeze;
    logic flush;
    logic stall;
    logic raw_hazard;
    logic issue;

    function automatic logic match(input slot_t s, input logic [4:0] src);
        return s.valid & s.wb & (s.dest == src) & (src != 5'd0);
    endfunction

    assign id_slot = {1'b1, hz.ID_Dest, hz.ID_WB_En, hz.ID_MEM_R_En, hz.ID_MEM_W_En};

    // WB is never checked: the register file writes on the falling edge, so
    // ID already reads the WB result in the same cycle.
    always_comb begin
        raw_hazard = 1'b0;
        if (FORWARD_EN) begin
            raw_hazard = exe_q.memr &
                         (match(exe_q, hz.ID_Src1) |
                          (hz.ID_Two_Src & match(exe_q, hz.ID_Src2)));
        end else begin
            raw_hazard = match(exe_q, hz.ID_Src1) | match(mem_q, hz.ID_Src1) |
                         (hz.ID_Two_Src & (match(exe_q, hz.ID_Src2) |
                                           match(mem_q, hz.ID_Src2)));
        end
    end

    assign mem_op = mem_q.valid & (mem_q.memr | mem_q.memw);
    assign freeze = ((mstate_q == M_IDLE) & mem_op) | (mstate_q == M_BUSY);

    // Gating with rst_n keeps Flush/Hazard_Stall low while reset is held,
    // even if Branch_Taken or ID inputs are still toggling.
    assign flush = rst_n & hz.Branch_Taken & ~freeze;
    assign stall = rst_n & raw_hazard & hz.ID_Valid & ~flush & ~freeze;
    assign issue = hz.ID_Valid & ~stall & ~flush;

    always_comb begin
        exe_d = exe_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!freeze) begin
            wb_d  = mem_q;
            mem_d = exe_q;
            exe_d = issue ? id_slot : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_q <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            exe_q <= exe_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // M_DONE is a one-cycle release: Freeze drops so the finished op leaves
    // MEM; a following op entering MEM restarts from M_IDLE without a gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstate_q <= M_IDLE;
        end else begin
            case (mstate_q)
                M_IDLE:  if (mem_op) mstate_q <= M_BUSY;
                M_BUSY:  if (hz.SRAM_Ready) mstate_q <= M_DONE;
                M_DONE:  mstate_q <= M_IDLE;
                default: mstate_q <= M_IDLE;
            endcase
        end
    end

    assign hz.Hazard_Stall = stall;
    assign hz.Flush        = flush;
    assign hz.Freeze       = freeze;
    assign hz.SRAM_Req     = freeze;
    assign hz.Scoreboard   = {exe_q, mem_q, wb_q};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if if_nf ();
    pipeline_hazard_ctrl_if if_fw ();

    pipeline_hazard_ctrl #(.FORWARD_EN(1'b0)) u_nf (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (if_nf.slave)
    );

    pipeline_hazard_ctrl #(.FORWARD_EN(1'b1)) u_fw (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (if_fw.slave)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] s1;
        logic [4:0] s2;
        logic       two;
        logic [4:0] d;
        logic       wb;
        logic       mr;
        logic       mw;
    } id_t;

    // o = {Hazard_Stall, Flush, Freeze, SRAM_Req}; vld = {EXE, MEM, WB} valid
    typedef struct packed {
        logic [3:0] o;
        logic [2:0] vld;
    } exp_t;

    localparam id_t NOP = '0;

    exp_t q_nf[$];
    exp_t q_fw[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   vec_no = 0;

    function automatic id_t ins(input logic [4:0] s1, input logic [4:0] s2,
                                input logic two, input logic [4:0] d,
                                input logic wb, input logic mr, input logic mw);
        return {1'b1, s1, s2, two, d, wb, mr, mw};
    endfunction

    task automatic put_nf(input id_t id, input logic bt, input logic rdy);
        if_nf.ID_Valid     = id.v;
        if_nf.ID_Src1      = id.s1;
        if_nf.ID_Src2      = id.s2;
        if_nf.ID_Two_Src   = id.two;
        if_nf.ID_Dest      = id.d;
        if_nf.ID_WB_En     = id.wb;
        if_nf.ID_MEM_R_En  = id.mr;
        if_nf.ID_MEM_W_En  = id.mw;
        if_nf.Branch_Taken = bt;
        if_nf.SRAM_Ready   = rdy;
    endtask

    task automatic put_fw(input id_t id, input logic bt, input logic rdy);
        if_fw.ID_Valid     = id.v;
        if_fw.ID_Src1      = id.s1;
        if_fw.ID_Src2      = id.s2;
        if_fw.ID_Two_Src   = id.two;
        if_fw.ID_Dest      = id.d;
        if_fw.ID_WB_En     = id.wb;
        if_fw.ID_MEM_R_En  = id.mr;
        if_fw.ID_MEM_W_En  = id.mw;
        if_fw.Branch_Taken = bt;
        if_fw.SRAM_Ready   = rdy;
    endtask

    // One cycle of stimulus on the chosen DUT; the expected response for this
    // cycle goes into that DUT's queue for the monitor.
    task automatic vec(input bit fw, input id_t id, input logic bt, input logic rdy,
                       input logic [3:0] o, input logic [2:0] vld);
        @(posedge clk);
        #1;
        if (fw) begin
            put_fw(id, bt, rdy);
            put_nf(NOP, 1'b0, 1'b0);
            q_fw.push_back({o, vld});
        end else begin
            put_nf(id, bt, rdy);
            put_fw(NOP, 1'b0, 1'b0);
            q_nf.push_back({o, vld});
        end
    endtask

    task automatic compare(input string tag, input exp_t e,
                           input logic [3:0] o, input logic [2:0] vld);
        n_chk++;
        if (o !== e.o) begin
            n_fail++;
            $display("FAIL %s_ctrl #%0d: stall/flush/freeze/req got %b required %b",
                     tag, vec_no, o, e.o);
        end
        n_chk++;
        if (vld !== e.vld) begin
            n_fail++;
            $display("FAIL %s_slots #%0d: exe/mem/wb valid got %b required %b",
                     tag, vec_no, vld, e.vld);
        end
    endtask

    // Monitor: samples away from the rising edge; the reset trigger lets the
    // bench observe the asynchronous clear mid-cycle.
    always @(negedge clk or negedge rst_n) begin
        #1;
        if (q_nf.size() > 0) begin
            compare("nf", q_nf.pop_front(),
                    {if_nf.Hazard_Stall, if_nf.Flush, if_nf.Freeze, if_nf.SRAM_Req},
                    {if_nf.Scoreboard[26], if_nf.Scoreboard[17], if_nf.Scoreboard[8]});
            vec_no++;
        end
        if (q_fw.size() > 0) begin
            compare("fw", q_fw.pop_front(),
                    {if_fw.Hazard_Stall, if_fw.Flush, if_fw.Freeze, if_fw.SRAM_Req},
                    {if_fw.Scoreboard[26], if_fw.Scoreboard[17], if_fw.Scoreboard[8]});
            vec_no++;
        end
    end

    id_t add1, con, st, ld9, ld3, sub;

    initial begin
        rst_n = 1'b0;
        put_nf(NOP, 1'b0, 1'b0);
        put_fw(NOP, 1'b0, 1'b0);
        add1 = ins(5'd2, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
        con  = ins(5'd1, 5'd4, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
        st   = ins(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        ld9  = ins(5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
        ld3  = ins(5'd4, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        sub  = ins(5'd3, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);

        // Reset held with busy inputs: everything stays low, slots empty
        vec(0, ins(5'd1, 5'd1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0), 1'b1, 1'b1, 4'b0000, 3'b000);
        vec(1, ins(5'd1, 5'd1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0), 1'b1, 1'b1, 4'b0000, 3'b000);
        @(posedge clk);
        #1;
        put_nf(NOP, 1'b0, 1'b0);
        put_fw(NOP, 1'b0, 1'b0);
        rst_n = 1'b1;

        // No forwarding: back-to-back dependence -> 2 stalls, 2 bubbles
        vec(0, add1, 0, 0, 4'b0000, 3'b000);
        vec(0, con,  0, 0, 4'b1000, 3'b100);
        vec(0, con,  0, 0, 4'b1000, 3'b010);
        vec(0, con,  0, 0, 4'b0000, 3'b001);
        vec(0, NOP,  0, 0, 4'b0000, 3'b100);
        vec(0, NOP,  0, 0, 4'b0000, 3'b010);
        // One independent instruction between -> 1 stall
        vec(0, ins(5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0), 0, 0, 4'b0000, 3'b001);
        vec(0, ins(5'd9, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0), 0, 0, 4'b0000, 3'b100);
        vec(0, ins(5'd7, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0), 0, 0, 4'b1000, 3'b110);
        vec(0, ins(5'd7, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0), 0, 0, 4'b0000, 3'b011);
        vec(0, NOP, 0, 0, 4'b0000, 3'b101);
        vec(0, NOP, 0, 0, 4'b0000, 3'b010);
        vec(0, NOP, 0, 0, 4'b0000, 3'b001);
        vec(0, NOP, 0, 0, 4'b0000, 3'b000);

        // R0 producer/consumer, and unused Src2 matching a producer
        vec(0, ins(5'd5,  5'd0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0), 0, 0, 4'b0000, 3'b000);
        vec(0, ins(5'd0,  5'd0, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0), 0, 0, 4'b0000, 3'b100);
        vec(0, ins(5'd12, 5'd0, 1'b0, 5'd6,  1'b1, 1'b0, 1'b0), 0, 0, 4'b0000, 3'b110);
        vec(0, ins(5'd11, 5'd6, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0), 0, 0, 4'b0000, 3'b111);
        vec(0, NOP, 0, 0, 4'b0000, 3'b111);
        vec(0, NOP, 0, 0, 4'b0000, 3'b011);
        vec(0, NOP, 0, 0, 4'b0000, 3'b001);
        vec(0, NOP, 0, 0, 4'b0000, 3'b000);

        // ST handshake (ready on 4th frozen cycle), then LD back-to-back
        vec(0, st,  0, 0, 4'b0000, 3'b000);
        vec(0, ld9, 0, 0, 4'b0000, 3'b100);
        vec(0, NOP, 0, 0, 4'b0011, 3'b110);
        vec(0, NOP, 0, 0, 4'b0011, 3'b110);
        vec(0, NOP, 0, 0, 4'b0011, 3'b110);
        vec(0, NOP, 0, 1, 4'b0011, 3'b110);
        vec(0, NOP, 0, 0, 4'b0000, 3'b110);
        vec(0, NOP, 0, 1, 4'b0011, 3'b011);
        vec(0, NOP, 0, 1, 4'b0011, 3'b011);
        vec(0, NOP, 0, 0, 4'b0000, 3'b011);
        vec(0, NOP, 0, 0, 4'b0000, 3'b001);
        vec(0, NOP, 0, 0, 4'b0000, 3'b000);

        // Reset asserted while in M_BUSY: outputs drop without an edge
        vec(0, st,  0, 0, 4'b0000, 3'b000);
        vec(0, NOP, 0, 0, 4'b0000, 3'b100);
        vec(0, NOP, 0, 0, 4'b0011, 3'b010);
        vec(0, NOP, 0, 0, 4'b0011, 3'b010);
        #6;
        q_nf.push_back({4'b0000, 3'b000});
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vec(0, NOP, 0, 0, 4'b0000, 3'b000);
        vec(0, st,  0, 0, 4'b0000, 3'b000);
        vec(0, NOP, 0, 0, 4'b0000, 3'b100);
        vec(0, NOP, 0, 1, 4'b0011, 3'b010);
        vec(0, NOP, 0, 1, 4'b0011, 3'b010);
        vec(0, NOP, 0, 0, 4'b0000, 3'b010);
        vec(0, NOP, 0, 0, 4'b0000, 3'b001);
        vec(0, NOP, 0, 0, 4'b0000, 3'b000);

        // Forwarding: ALU dependence free, load-use exactly 1 stall, 2-cycle freeze
        vec(1, add1, 0, 0, 4'b0000, 3'b000);
        vec(1, con,  0, 0, 4'b0000, 3'b100);
        vec(1, ld3,  0, 0, 4'b0000, 3'b110);
        vec(1, sub,  0, 0, 4'b1000, 3'b111);
        vec(1, sub,  0, 0, 4'b0011, 3'b011);
        vec(1, sub,  0, 1, 4'b0011, 3'b011);
        vec(1, sub,  0, 0, 4'b0000, 3'b011);
        vec(1, NOP,  0, 0, 4'b0000, 3'b101);
        vec(1, NOP,  0, 0, 4'b0000, 3'b010);
        vec(1, NOP,  0, 0, 4'b0000, 3'b001);
        vec(1, NOP,  0, 0, 4'b0000, 3'b000);

        // Branch beats load-use hazard; branch ignored while frozen
        vec(1, ld3, 0, 0, 4'b0000, 3'b000);
        vec(1, ins(5'd3, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0), 1, 0, 4'b0100, 3'b100);
        vec(1, NOP, 1, 0, 4'b0011, 3'b010);
        vec(1, NOP, 1, 1, 4'b0011, 3'b010);
        vec(1, NOP, 0, 0, 4'b0000, 3'b010);
        vec(1, NOP, 0, 0, 4'b0000, 3'b001);
        vec(1, NOP, 0, 0, 4'b0000, 3'b000);

        // Load-use through Src2 only; SRAM_Ready ignored in M_IDLE and M_DONE
        vec(1, ld3, 0, 0, 4'b0000, 3'b000);
        vec(1, ins(5'd0, 5'd3, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0), 0, 0, 4'b1000, 3'b100);
        vec(1, NOP, 0, 1, 4'b0011, 3'b010);
        vec(1, NOP, 0, 1, 4'b0011, 3'b010);
        vec(1, NOP, 0, 1, 4'b0000, 3'b010);
        vec(1, NOP, 0, 0, 4'b0000, 3'b001);
        vec(1, NOP, 0, 0, 4'b0000, 3'b000);

        @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
